// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial sequence detector: counts pattern matches on x and flags done at a target count.
// Define SEQ_DET_TIMEOUT_EN to add the timeout output, which ends a run after TIMEOUT valid bits without a match.
module seq_detect_ctrl #(
    parameter int PW      = 8,
    parameter int LW      = 4,
    parameter int CW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_target,
    output logic          cfg_err,
    input  logic          start,
    input  logic          abort,
    input  logic          x,
    input  logic          x_valid,
    output logic          y,
    output logic          busy,
    output logic          done,
`ifdef SEQ_DET_TIMEOUT_EN
    output logic          timeout,
`endif
    output logic [CW-1:0] match_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pat_q, hist, hist_nxt;
    logic [LW-1:0] len_q, bcnt, bcnt_inc;
    logic [CW-1:0] tgt_q, cnt_inc;
    logic          ovl_q, cfg_seen;
    logic          cfg_xfer, arm, sample, hit, tgt_hit, to_hit;

    function automatic logic [LW-1:0] sat_bits(input logic [LW-1:0] c);
        return (c >= LW'(PW)) ? c : c + 1'b1;
    endfunction

    function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [PW-1:0] len_mask(input logic [LW-1:0] l);
        logic [PW-1:0] m;
        for (int i = 0; i < PW; i++) m[i] = (i < int'(l));
        return m;
    endfunction

    assign cfg_xfer = cfg_valid && (state != RUN);
    // abort beats start, and only a clean accepted config may be armed
    assign arm      = start && !abort && cfg_seen && !cfg_err && (state != RUN);
    assign sample   = (state == RUN) && x_valid && !abort;
    assign hist_nxt = {hist[PW-2:0], x};
    assign bcnt_inc = sat_bits(bcnt);
    assign cnt_inc  = sat_cnt(match_count);
    assign hit      = sample && (bcnt_inc >= len_q) &&
                      (((hist_nxt ^ pat_q) & len_mask(len_q)) == '0);
    assign tgt_hit  = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_inc;
    assign tcnt_inc = tcnt + 1'b1;
    assign to_hit   = sample && !hit && (tcnt_inc == TW'(TIMEOUT));
`else
    localparam int unused_timeout = TIMEOUT;
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state == RUN);
        cfg_ready = (state != RUN);
        case (state)
            IDLE:    if (arm) state_nxt = RUN;
            RUN: begin
                if (abort)                  state_nxt = IDLE;
                else if (tgt_hit || to_hit) state_nxt = DONE;
            end
            DONE: begin
                if (arm)           state_nxt = RUN;
                else if (cfg_xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            cfg_seen    <= 1'b0;
            cfg_err     <= 1'b0;
            hist        <= '0;
            bcnt        <= '0;
            match_count <= '0;
            y           <= 1'b0;
            done        <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            tcnt        <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            y <= hit;
            if (cfg_xfer) begin
                pat_q    <= cfg_pattern;
                len_q    <= cfg_len;
                ovl_q    <= cfg_overlap;
                tgt_q    <= cfg_target;
                cfg_seen <= 1'b1;
                cfg_err  <= (cfg_len == '0) || (cfg_len > LW'(PW));
            end
            if (arm) begin
                hist        <= '0;
                bcnt        <= '0;
                match_count <= '0;
`ifdef SEQ_DET_TIMEOUT_EN
                tcnt        <= '0;
`endif
            end else if (sample) begin
                hist <= hist_nxt;
                // without overlap the matched bits must not count towards the next match
                bcnt <= (hit && !ovl_q) ? '0 : bcnt_inc;
                if (hit) match_count <= cnt_inc;
`ifdef SEQ_DET_TIMEOUT_EN
                tcnt <= hit ? '0 : tcnt_inc;
`endif
            end
            if (arm || cfg_xfer)        done <= 1'b0;
            else if (tgt_hit || to_hit) done <= 1'b1;
`ifdef SEQ_DET_TIMEOUT_EN
            if (arm || cfg_xfer) timeout <= 1'b0;
            else if (to_hit)     timeout <= 1'b1;
`endif
        end
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-time programmable serial sequence-detector controller; generalises the fixed "101" Mealy/Moore detectors.
- Accepts a pattern configuration over a valid/ready handshake and arms/disarms detection on the serial stream x.
- Counts matches and signals completion when a programmed match target is reached.
- Sits between the control/CSR side and the serial bit source.

Parameters:
- PW, 8, maximum pattern length in bits.
- LW, 4, width of cfg_len; must be at least clog2(PW)+1.
- CW, 8, width of the match counter and target.
- TIMEOUT, 64, bit-count timeout; only used when SEQ_DET_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_pattern  in  PW  pattern; bit cfg_len-1 is expected first, bit 0 last.
- cfg_len  in  LW  pattern length; legal range 1..PW.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_target  in  CW  matches to reach before done; 0 = unlimited.
- cfg_err  out  1  last accepted config had an illegal length.
- start  in  1  arm detection (single-cycle pulse).
- abort  in  1  disarm detection.
- x  in  1  serial data bit.
- x_valid  in  1  x is valid this cycle.
- y  out  1  one-cycle match pulse.
- busy  out  1  state is RUN.
- done  out  1  target reached; held until start or a config transfer.
- match_count  out  CW  matches counted since last arm.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all outputs 0 except cfg_ready=1; history, bit counter and stored config cleared. Reset mid-RUN discards everything immediately.
- States: IDLE, RUN, DONE.
- cfg_ready=1 in IDLE and DONE; 0 in RUN. A transfer occurs when cfg_valid && cfg_ready.
  - Transfer latches pattern, len, overlap and target.
  - Sets cfg_err = (len==0 || len>PW).
  - Transfer in DONE moves to IDLE and clears done.
- Arming:
  - IDLE/DONE -> RUN on start, only if a config has been accepted since reset and cfg_err=0; otherwise start is ignored.
  - Arming clears match_count, done, the history register and the valid-bit counter.
- Abort: RUN -> IDLE on abort; match_count is retained; no y pulse. If start and abort occur in the same cycle, abort wins.
- Sampling: only in RUN, and only when x_valid=1. x shifts into the LSB of a PW-bit history register; the valid-bit counter increments and saturates at PW.
- Match condition: counter >= len and history[len-1:0] == pattern[len-1:0], evaluated on the shifted value that includes the new bit.
- Match outputs:
  - y is a registered pulse, high for exactly the one cycle after the sampling edge (latency 1).
  - match_count increments on the same edge and saturates at 2^CW-1.
- Overlap:
  - cfg_overlap=1: history is retained after a match.
  - cfg_overlap=0: the valid-bit counter resets to 0 on a match, so bits of the matched sequence cannot be reused.
- Completion: when target!=0 and the incremented count equals target, go RUN -> DONE; done rises in the same cycle as the final y pulse.
- In IDLE/DONE, x is ignored and y=0.
- Samples with x_valid=0 leave all state unchanged.

Optional Feature:
- Macro: SEQ_DET_TIMEOUT_EN.
- Defined: adds output port timeout (1 bit) and an internal counter of valid bits since arm or since the last match.
  - When that counter reaches TIMEOUT without a match, go RUN -> DONE with timeout=1 and done=1.
  - timeout clears under the same conditions as done.
  - A match on the TIMEOUT-th bit counts as a match; no timeout occurs in that case.
- Undefined: no timeout port; RUN is left only by target reached, abort, or reset.

Test Plan:
- Overlap case: config pattern=8'b101, len=3, overlap=1, target=0; start; stream x = 0,0,1,1,0,1,1,0,0,1,0,1,0,1,0,1,0,0 (x_valid=1) -> y pulses after bits 5, 11, 13, 15 (0-based); match_count=4; busy stays 1.
- Non-overlap case: same stream with overlap=0 -> y after bits 5, 11, 15; match_count=3.
- Target reached: overlap=1, target=2 -> done=1 and busy=0 with the y pulse for bit 11; later bits ignored; match_count holds 2; cfg_ready=1.
- Illegal length and abort:
  - len=0 config -> cfg_err=1; start ignored and busy stays 0.
  - Then a valid config and start; abort in the same cycle as a second start -> state IDLE, match_count retained.
- Gaps and async reset: x_valid toggling 1/0 around "1,0,1" -> exactly one y pulse. reset_n low mid-RUN -> all outputs 0 and cfg_ready=1 without waiting for a clock edge.
- Timeout (SEQ_DET_TIMEOUT_EN, TIMEOUT=4): pattern 101; stream 0,0,0,0 -> timeout=1 and done=1 after the 4th bit. Stream 0,1,0,1 -> match on bit 3 and no timeout.
